// File: rtl/uni_bin_decoder.sv
// Unipolar bitstream to binary decoder: counts ones over a fixed window of
// 2^N-1 samples, or 2^N samples with a saturating clamp when UNI_BIN_DECODER_CLAMP_EN is defined.
`ifndef INWD
`define INWD 8
`endif

module uni_bin_decoder (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iBit,
  input  logic             start,
  input  logic             clear,
  input  logic             iReady,
  output logic [`INWD-1:0] oValue,
  output logic             oValid,
  output logic             busy
);

  localparam int N = `INWD;

`ifdef UNI_BIN_DECODER_CLAMP_EN
  localparam logic [N:0] WIN_LEN = {1'b1, {N{1'b0}}};
`else
  localparam logic [N:0] WIN_LEN = {1'b0, {N{1'b1}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N:0]     count_q, count_d;
  logic [N:0]     win_q,   win_d;
  logic [N-1:0]   value_q, value_d;

  logic [N:0]     count_inc;
  logic [N:0]     win_inc;
  logic [N-1:0]   result;

  assign count_inc = count_q + {{N{1'b0}}, iBit};
  assign win_inc   = win_q + {{N{1'b0}}, 1'b1};

  // The final sample is folded in combinationally so the result lands on the
  // same edge that takes the last sample.
`ifdef UNI_BIN_DECODER_CLAMP_EN
  assign result = count_inc[N] ? {N{1'b1}} : count_inc[N-1:0];
`else
  assign result = count_inc[N-1:0];
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    count_d = count_q;
    win_d   = win_q;
    value_d = value_q;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      win_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACC;
            count_d = '0;
            win_d   = '0;
          end
        end
        ACC: begin
          count_d = count_inc;
          win_d   = win_inc;
          if (win_inc == WIN_LEN) begin
            state_d = HOLD;
            value_d = result;
          end
        end
        HOLD: begin
          if (iReady) begin
            if (start) begin
              state_d = ACC;
              count_d = '0;
              win_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      win_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      win_q   <= win_d;
      value_q <= value_d;
    end
  end

  assign oValue = value_q;
  assign oValid = (state_q == HOLD);
  assign busy   = (state_q == ACC);

endmodule
